// File: rtl/apb_arbiter_master.sv
// Two-requester round-robin arbiter driving a single APB master port.
// Optional ACCESS-phase timeout is compiled in with `define APB_ARB_TIMEOUT_EN.
module apb_arbiter_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic [1:0]              req_valid,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]              req_write,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  input  logic [2*STRB_WIDTH-1:0] req_strb,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [STRB_WIDTH-1:0]   pstrb,
  output logic                    psel,
  output logic                    penable,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state;
  logic                  rr;
  logic                  grant;
  logic                  gnt_c;
  logic                  launch;
  logic                  done;
  logic                  timeout_hit;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_write;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_strb;

  // rr names the requester that wins when both ask at once
  always_comb begin
    gnt_c     = (req_valid == 2'b11) ? rr : req_valid[1];
    sel_addr  = gnt_c ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]  : req_addr[ADDR_WIDTH-1:0];
    sel_wdata = gnt_c ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
    sel_strb  = gnt_c ? req_strb[2*STRB_WIDTH-1:STRB_WIDTH]  : req_strb[STRB_WIDTH-1:0];
    sel_write = req_write[gnt_c];
    done      = (state == ACCESS) && (pready || timeout_hit);
    launch    = (|req_valid) && ((state == IDLE) || done);
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcount;

  // Fires on the last permitted ACCESS cycle that still sees pready low
  assign timeout_hit = !pready && (tcount == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tcount <= '0;
    end else if (state == SETUP) begin
      tcount <= '0;
    end else if ((state == ACCESS) && !pready && !timeout_hit) begin
      tcount <= tcount + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= IDLE;
      rr         <= 1'b0;
      grant      <= 1'b0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
      paddr      <= '0;
      pwrite     <= 1'b0;
      pwdata     <= '0;
      pstrb      <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: ;
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            rsp_valid[grant] <= 1'b1;
            rsp_rdata        <= (pwrite || !pready) ? '0 : prdata;
            rsp_slverr       <= pready ? pslverr : 1'b1;
            psel             <= 1'b0;
            penable          <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // A new grant overrides the IDLE return above, giving back-to-back transfers
      if (launch) begin
        state     <= SETUP;
        grant     <= gnt_c;
        rr        <= ~gnt_c;
        req_ready <= 2'b01 << gnt_c;
        psel      <= 1'b1;
        penable   <= 1'b0;
        paddr     <= sel_addr;
        pwrite    <= sel_write;
        pwdata    <= sel_wdata;
        pstrb     <= sel_write ? sel_strb : '0;
      end
    end
  end

endmodule
